// File: rtl/quad_enc_gen.sv
// Quadrature encoder pattern generator: turns single-cycle CW/CCW step requests
// into a Gray-coded A/B sequence, holding each state for PHASE_CYCLES clocks.
module quad_enc_gen #(
  parameter int PHASE_CYCLES = 1000,
  parameter int CNT_W        = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    step_cw,
  input  logic                    step_ccw,
  output logic                    enc_a,
  output logic                    enc_b,
  output logic                    busy,
  output logic signed [CNT_W-1:0] pending,
  output logic                    drop
);

  localparam int                     TMR_W    = $clog2(PHASE_CYCLES);
  localparam logic [TMR_W-1:0]       TMR_LOAD = TMR_W'(PHASE_CYCLES - 1);
  localparam logic signed [CNT_W+1:0] ONE     = (CNT_W+2)'(1);
  localparam logic signed [CNT_W+1:0] NEG_ONE = '1;
  localparam logic signed [CNT_W+1:0] PEND_MAX = {3'b000, {(CNT_W-1){1'b1}}};
  localparam logic signed [CNT_W+1:0] PEND_MIN = {3'b111, {(CNT_W-1){1'b0}}};

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                    state, state_next;
  logic [TMR_W-1:0]          timer, timer_next;
  logic                      step_now, dir_cw;
  logic                      a_next, b_next, busy_next, drop_next;
  logic signed [CNT_W+1:0]   pend_ext, req_delta, consume, sum, clamped;
  logic signed [CNT_W-1:0]   pending_next;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    timer_next = timer;
    step_now   = 1'b0;

    case (state)
      IDLE: step_now = (pending != '0);
      HOLD: begin
        if (timer == '0) begin
          if (pending != '0) step_now = 1'b1;
          else               state_next = IDLE;
        end else begin
          timer_next = timer - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    if (step_now) begin
      state_next = HOLD;
      timer_next = TMR_LOAD;
    end

    // Direction follows the sign of the backlog; only meaningful when nonzero.
    dir_cw  = ~pending[CNT_W-1];
    consume = step_now ? (dir_cw ? ONE : NEG_ONE) : '0;

    // Simultaneous CW and CCW requests cancel out.
    if (step_cw && !step_ccw)      req_delta = ONE;
    else if (step_ccw && !step_cw) req_delta = NEG_ONE;
    else                           req_delta = '0;

    pend_ext = {{2{pending[CNT_W-1]}}, pending};
    sum      = pend_ext + req_delta - consume;

    drop_next = 1'b0;
    clamped   = sum;
    if (sum > PEND_MAX) begin
      clamped   = PEND_MAX;
      drop_next = 1'b1;
    end else if (sum < PEND_MIN) begin
      clamped   = PEND_MIN;
      drop_next = 1'b1;
    end
    pending_next = clamped[CNT_W-1:0];

    // One Gray step: CW walks 00->10->11->01, CCW walks it backwards.
    a_next = enc_a;
    b_next = enc_b;
    if (step_now) begin
      if (dir_cw) begin
        a_next = ~enc_b;
        b_next = enc_a;
      end else begin
        a_next = enc_b;
        b_next = ~enc_a;
      end
    end

    busy_next = (state_next == HOLD) || (pending_next != '0);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      timer   <= '0;
      pending <= '0;
      enc_a   <= 1'b0;
      enc_b   <= 1'b0;
      busy    <= 1'b0;
      drop    <= 1'b0;
    end else begin
      state   <= state_next;
      timer   <= timer_next;
      pending <= pending_next;
      enc_a   <= a_next;
      enc_b   <= b_next;
      busy    <= busy_next;
      drop    <= drop_next;
    end
  end

endmodule

// File: tb/tb_quad_enc_gen.sv
// Randomized and directed bench for quad_enc_gen against a behavioural model
// that tracks position on the Gray wheel and a backlog integer.
module tb_quad_enc_gen;

  localparam int PH   = 4;
  localparam int CW   = 4;
  localparam int PMAX = 7;
  localparam int PMIN = -8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic step_cw = 1'b0;
  logic step_ccw = 1'b0;
  logic enc_a, enc_b, busy, drop;
  logic signed [CW-1:0] pending;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model
  int   m_pend, m_pos, m_cool, m_peak, m_min, m_drops, m_net;
  bit   m_hold, m_busy, m_drop;
  logic [1:0] gray [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  // Observation log
  int         cyc;
  int         chg_cyc[$];
  logic [1:0] chg_ab[$];
  logic [1:0] last_ab;
  int         obs_peak, obs_min, obs_drops, bad_hops;

  quad_enc_gen #(.PHASE_CYCLES(PH), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .step_cw(step_cw), .step_ccw(step_ccw),
    .enc_a(enc_a), .enc_b(enc_b), .busy(busy), .pending(pending), .drop(drop)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pend = 0; m_pos = 0; m_cool = 0; m_hold = 0; m_busy = 0; m_drop = 0;
    m_peak = 0; m_min = 0; m_drops = 0; m_net = 0;
    cyc = 0; chg_cyc.delete(); chg_ab.delete(); last_ab = 2'b00;
    obs_peak = 0; obs_min = 0; obs_drops = 0; bad_hops = 0;
  endtask

  task automatic model_step(input bit cw, input bit ccw);
    bit emit;
    int dir, nxt;
    emit = (m_pend != 0) && (!m_hold || m_cool == 0);
    dir  = (m_pend > 0) ? 1 : -1;
    nxt  = m_pend + int'(cw) - int'(ccw) - (emit ? dir : 0);
    m_drop = (nxt > PMAX) || (nxt < PMIN);
    if (nxt > PMAX) nxt = PMAX;
    if (nxt < PMIN) nxt = PMIN;
    if (m_drop) m_drops++;
    if (emit) begin
      m_pos  = (m_pos + dir + 4) % 4;
      m_net += dir;
      m_hold = 1;
      m_cool = PH - 1;
    end else if (m_hold) begin
      if (m_cool == 0) m_hold = 0;
      else m_cool--;
    end
    m_pend = nxt;
    m_busy = m_hold || (m_pend != 0);
    if (m_pend > m_peak) m_peak = m_pend;
    if (m_pend < m_min)  m_min  = m_pend;
  endtask

  // Apply one cycle of requests, advance the model, sample #1 after the edge.
  task automatic tick(input bit cw, input bit ccw);
    step_cw  = cw;
    step_ccw = ccw;
    @(posedge clk);
    model_step(cw, ccw);
    #1;
    cyc++;
    if ({enc_a, enc_b} != last_ab) begin
      if ($countones({enc_a, enc_b} ^ last_ab) != 1) bad_hops++;
      chg_cyc.push_back(cyc);
      chg_ab.push_back({enc_a, enc_b});
      last_ab = {enc_a, enc_b};
    end
    if (int'(pending) > obs_peak) obs_peak = int'(pending);
    if (int'(pending) < obs_min)  obs_min  = int'(pending);
    if (drop) obs_drops++;
    step_cw  = 1'b0;
    step_ccw = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; step_cw = 1'b0; step_ccw = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    vectors++;
    if ({enc_a, enc_b, busy, drop} !== 4'b0000 || pending !== '0) begin
      miscompares++;
      $display("FAIL reset_state: ab=%b busy=%b drop=%b pending=%0d, need all zero",
               {enc_a, enc_b}, busy, drop, pending);
    end
    // A request presented while reset falls is accepted on the first edge.
    model_reset();
    step_cw = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    model_step(1, 0);
    #1;
    step_cw = 1'b0;
    vectors++;
    if (int'(pending) !== 1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_req: pending=%0d busy=%b, need 1 1", pending, busy);
    end
  endtask

  task automatic test_single();
    int busy_cnt;
    do_reset();
    tick(1, 0);
    vectors++;
    if (int'(pending) !== 1 || {enc_a, enc_b} !== 2'b00) begin
      miscompares++;
      $display("FAIL single_n1: pending=%0d ab=%b, need 1 00", pending, {enc_a, enc_b});
    end
    busy_cnt = busy ? 1 : 0;
    tick(0, 0);
    vectors++;
    if ({enc_a, enc_b} !== 2'b10 || pending !== '0) begin
      miscompares++;
      $display("FAIL single_n2: ab=%b pending=%0d, need 10 0", {enc_a, enc_b}, pending);
    end
    while (busy && busy_cnt < 20) begin
      busy_cnt++;
      tick(0, 0);
    end
    vectors++;
    if (busy_cnt !== 5) begin
      miscompares++;
      $display("FAIL single_busy_len: %0d cycles, need 5", busy_cnt);
    end
    repeat (3) tick(0, 0);
    vectors++;
    if ({enc_a, enc_b} !== 2'b10 || pending !== '0 || busy !== 1'b0 || chg_ab.size() != 1) begin
      miscompares++;
      $display("FAIL single_idle: ab=%b pending=%0d busy=%b changes=%0d, need 10 0 0 1",
               {enc_a, enc_b}, pending, busy, chg_ab.size());
    end
  endtask

  task automatic test_three();
    logic [1:0] exp_seq [3];
    int n;
    exp_seq = '{2'b10, 2'b11, 2'b01};
    do_reset();
    repeat (3) tick(1, 0);
    n = 0;
    while ((busy || n == 0) && n < 40) begin
      tick(0, 0);
      n++;
    end
    vectors++;
    if (chg_ab.size() != 3) begin
      miscompares++;
      $display("FAIL three_count: %0d transitions, need 3", chg_ab.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (chg_ab[i] !== exp_seq[i]) begin
          miscompares++;
          $display("FAIL three_seq[%0d]: ab=%b, need %b", i, chg_ab[i], exp_seq[i]);
        end
      end
      for (int i = 1; i < 3; i++) begin
        vectors++;
        if (chg_cyc[i] - chg_cyc[i-1] != PH) begin
          miscompares++;
          $display("FAIL three_gap[%0d]: %0d cycles, need %0d", i, chg_cyc[i] - chg_cyc[i-1], PH);
        end
      end
    end
    vectors++;
    if (obs_peak != m_peak || pending !== '0) begin
      miscompares++;
      $display("FAIL three_peak: peak=%0d final=%0d, need %0d 0", obs_peak, pending, m_peak);
    end
  endtask

  task automatic test_saturate();
    int n;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      tick(1, 0);
      vectors++;
      if (drop !== m_drop || int'(pending) !== m_pend) begin
        miscompares++;
        $display("FAIL sat_cycle%0d: drop=%b pending=%0d, need %b %0d", i, drop, pending, m_drop, m_pend);
      end
    end
    n = 0;
    while (busy && n < 100) begin
      tick(0, 0);
      n++;
    end
    vectors++;
    if (obs_peak != PMAX || obs_drops != 3 || obs_drops != m_drops) begin
      miscompares++;
      $display("FAIL sat_drops: peak=%0d drops=%0d, need %0d 3", obs_peak, obs_drops, PMAX);
    end
    vectors++;
    if (chg_ab.size() != 11 || busy !== 1'b0 || {enc_a, enc_b} !== gray[m_pos]) begin
      miscompares++;
      $display("FAIL sat_transitions: %0d ab=%b busy=%b, need 11 %b 0",
               chg_ab.size(), {enc_a, enc_b}, busy, gray[m_pos]);
    end
  endtask

  task automatic test_reverse();
    int n;
    do_reset();
    repeat (3) tick(1, 0);
    vectors++;
    if (int'(pending) !== 2) begin
      miscompares++;
      $display("FAIL rev_setup: pending=%0d, need 2", pending);
    end
    repeat (3) tick(0, 1);
    n = 0;
    while (busy && n < 60) begin
      tick(0, 0);
      n++;
    end
    vectors++;
    if (obs_min != -1 || bad_hops != 0) begin
      miscompares++;
      $display("FAIL rev_path: min_pending=%0d bad_hops=%0d, need -1 0", obs_min, bad_hops);
    end
    vectors++;
    if ({enc_a, enc_b} !== gray[(m_net % 4 + 4) % 4] || chg_ab.size() != 2) begin
      miscompares++;
      $display("FAIL rev_final: ab=%b changes=%0d, need %b 2",
               {enc_a, enc_b}, chg_ab.size(), gray[(m_net % 4 + 4) % 4]);
    end
  endtask

  task automatic test_cancel();
    do_reset();
    tick(1, 1);
    repeat (6) begin
      vectors++;
      if (pending !== '0 || drop !== 1'b0 || busy !== 1'b0 || {enc_a, enc_b} !== 2'b00) begin
        miscompares++;
        $display("FAIL cancel: pending=%0d drop=%b busy=%b ab=%b, need 0 0 0 00",
                 pending, drop, busy, {enc_a, enc_b});
      end
      tick(0, 0);
    end
  endtask

  task automatic test_reset_hold();
    do_reset();
    repeat (7) tick(1, 0);
    vectors++;
    if (int'(pending) !== 5 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_hold_setup: pending=%0d busy=%b, need 5 1", pending, busy);
    end
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if ({enc_a, enc_b} !== 2'b00 || pending !== '0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_hold_async: ab=%b pending=%0d busy=%b, need 00 0 0",
               {enc_a, enc_b}, pending, busy);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (20) tick(0, 0);
    vectors++;
    if (chg_ab.size() != 0 || pending !== '0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_hold_after: changes=%0d pending=%0d busy=%b, need 0 0 0",
               chg_ab.size(), pending, busy);
    end
  endtask

  task automatic test_random();
    bit cw, ccw;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      // Bursty traffic so both saturation and idle stretches occur.
      if ((i / 60) % 2 == 0) begin
        cw  = ($urandom_range(0, 2) != 0);
        ccw = ($urandom_range(0, 5) == 0);
      end else begin
        cw  = ($urandom_range(0, 9) == 0);
        ccw = ($urandom_range(0, 4) == 0);
      end
      tick(cw, ccw);
      vectors++;
      if ({enc_a, enc_b} !== gray[m_pos] || int'(pending) !== m_pend ||
          busy !== m_busy || drop !== m_drop) begin
        miscompares++;
        $display("FAIL random_cycle%0d: ab=%b pend=%0d busy=%b drop=%b, need %b %0d %b %b",
                 i, {enc_a, enc_b}, pending, busy, drop, gray[m_pos], m_pend, m_busy, m_drop);
      end
    end
    vectors++;
    if (bad_hops != 0) begin
      miscompares++;
      $display("FAIL random_gray: %0d multi-bit hops, need 0", bad_hops);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_three();
    test_saturate();
    test_reverse();
    test_cancel();
    test_reset_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
